arb_queue_2x8: RTL and testbench
================================

// Module: arb_queue_2x8
// PURPOSE
//  Two-requester, 2-entry, 8-bit ready/valid queue controller built around one ram_2x8 instance.
//  Arbitrates two enqueue sources and owns the RAM write/read pointers and full/empty tracking.
//  Presents one dequeue port in FIFO order.
//  Sits between producer lanes and a shared 8-bit consumer.
// PARAMETERS
//  ARB_RR  1  1: round-robin between enq0/enq1; 0: fixed priority, enq0 wins
//  FLOW    0  1: when empty, selected enq data bypasses RAM to deq in the same cycle
// PORTS
//  clock           in   1  single clock; RAM W0_clk/R0_clk tied here
//  reset           in   1  synchronous, active-high
//  io_enq0_valid   in   1  requester 0 has data
//  io_enq0_bits    in   8  requester 0 data
//  io_enq0_ready   out  1  requester 0 accepted this cycle when valid&ready
//  io_enq1_valid   in   1  requester 1 has data
//  io_enq1_bits    in   8  requester 1 data
//  io_enq1_ready   out  1  requester 1 accepted this cycle when valid&ready
//  io_deq_valid    out  1  head entry available
//  io_deq_bits     out  8  head entry data
//  io_deq_ready    in   1  consumer takes head when valid&ready
//  io_count        out  2  occupancy 0..2
//  io_chosen       out  1  index of requester selected this cycle (0 when none valid)
// BEHAVIOUR
//  State: enq_ptr, deq_ptr (1b each), maybe_full, last_grant (1b).
//   Reset values: 0, 0, 0, 1; enq0 wins the first tie.
//  ptr_match = enq_ptr==deq_ptr; empty = ptr_match&!maybe_full; full = ptr_match&maybe_full.
//  Selection is combinational from valids:
//   - Only one valid: that requester.
//   - Both valid, ARB_RR=0: enq0.
//   - Both valid, ARB_RR=1: ~last_grant.
//  io_enqN_ready = !full & (sel==N). Ready may depend on the other requester's valid; no valid->valid loop.
//  do_enq = sel_valid & !full & !(FLOW & empty & io_deq_ready).
//  do_deq = io_deq_ready & !empty.
//  RAM wiring: W0_en=do_enq, W0_addr=enq_ptr, W0_data=sel bits; R0_en=1, R0_addr=deq_ptr.
//   Read is combinational, so head data has zero latency.
//  io_deq_valid = !empty | (FLOW & sel_valid).
//  io_deq_bits  = (FLOW & empty) ? sel bits : R0_data.
//  Sequential updates:
//   - do_enq: enq_ptr flips (1->0 wraps).
//   - do_deq: deq_ptr flips.
//   - do_enq!=do_deq: maybe_full <= do_enq.
//   - Accepted handshake, including a FLOW bypass: last_grant <= sel.
//  Latency: enq accepted in cycle t -> visible on deq in t+1. With FLOW=1 and empty -> visible in t.
//  Simultaneous enq+deq at count 1: count stays 1, both pointers advance.
//  Full: both enq ready=0 regardless of deq_ready; no same-cycle pass-through at full.
//  Empty: deq_valid=0 (FLOW=0); deq_bits don't-care.
//  io_count = full ? 2 : {1'b0, enq_ptr^deq_ptr}.
//  Reset mid-operation: occupancy drops to 0 on the next edge.
//   RAM contents are not cleared but never observed: deq_valid=0 until a new enq.
//  During and after reset: io_count=0, io_deq_valid=0 (FLOW=0), both enq ready=1 when valid.
// TESTING
//  T1 reset; enq0 valid, bits 0x11, deq_ready=0 -> t+1: deq_valid=1, deq_bits=0x11, count=1.
//  T2 enq 0xA1 then 0xA2, deq_ready=0 -> count=2, enq0/enq1 ready=0; deq_ready=1 -> 0xA1 then 0xA2, count 1 then 0.
//  T3 ARB_RR=1, enq0=0x10 and enq1=0x20 held valid, deq_ready=1 -> accepts 0x10,0x20,0x10,0x20; io_chosen alternates.
//     ARB_RR=0 -> only 0x10 accepted.
//  T4 hold count=1, enq+deq every cycle for 6 items 0x01..0x06 -> count stays 1; output order 0x01..0x06 across pointer wraps.
//  T5 FLOW=1, empty, enq1 0x5A, deq_ready=1 -> same-cycle deq_valid=1, deq_bits=0x5A; W0_en=0; count stays 0.
//  T6 count=2, assert reset 1 cycle -> count=0, deq_valid=0; next enq 0x77 dequeues as 0x77, not stale data.

Source files
------------

// File: rtl/arb_queue_2x8.sv
// Two-requester, 2-entry, 8-bit ready/valid queue controller.
// Arbitrates two enqueue lanes into a 2x8 storage array and presents one FIFO-ordered
// dequeue port. The storage is read combinationally, so the head has zero latency.
//
// Parameters:
//   ARB_RR  1: round-robin between enq0/enq1 on a tie; 0: enq0 always wins a tie
//   FLOW    1: when empty, the selected enq data bypasses storage to deq in the same cycle
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   io_enqN_valid/bits  requester N data offer
//   io_enqN_ready       requester N accepted this cycle when valid & ready
//   io_deq_valid/bits   head entry
//   io_deq_ready        consumer takes head when valid & ready
//   io_count            occupancy 0..2
//   io_chosen           requester selected this cycle (0 when none valid)
module arb_queue_2x8 #(
  parameter bit ARB_RR = 1'b1,
  parameter bit FLOW   = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       io_enq0_valid,
  input  logic [7:0] io_enq0_bits,
  output logic       io_enq0_ready,
  input  logic       io_enq1_valid,
  input  logic [7:0] io_enq1_bits,
  output logic       io_enq1_ready,
  output logic       io_deq_valid,
  output logic [7:0] io_deq_bits,
  input  logic       io_deq_ready,
  output logic [1:0] io_count,
  output logic       io_chosen
);

  logic       enq_ptr_q, enq_ptr_d;
  logic       deq_ptr_q, deq_ptr_d;
  logic       maybe_full_q, maybe_full_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] mem_q [2];

  logic       ptr_match, empty, full;
  logic       sel, sel_valid;
  logic [7:0] sel_bits;
  logic [7:0] rd_data;
  logic       do_enq, do_deq;

  assign ptr_match = (enq_ptr_q == deq_ptr_q);
  assign empty     = ptr_match & ~maybe_full_q;
  assign full      = ptr_match & maybe_full_q;
  assign sel_valid = io_enq0_valid | io_enq1_valid;

  // Selection depends only on valids and last_grant, so ready never loops back to valid.
  always_comb begin
    sel = 1'b0;
    if (io_enq0_valid && io_enq1_valid) begin
      sel = ARB_RR ? ~last_grant_q : 1'b0;
    end else if (io_enq1_valid) begin
      sel = 1'b1;
    end
  end

  assign sel_bits = sel ? io_enq1_bits : io_enq0_bits;
  assign rd_data  = mem_q[deq_ptr_q];

  // A bypassed item goes straight to the consumer and must not also be stored.
  assign do_enq = sel_valid & ~full & ~(FLOW & empty & io_deq_ready);
  assign do_deq = io_deq_ready & ~empty;

  assign io_enq0_ready = ~full & ~sel;
  assign io_enq1_ready = ~full & sel;
  assign io_chosen     = sel;
  assign io_deq_valid  = ~empty | (FLOW & sel_valid);
  assign io_deq_bits   = (FLOW & empty) ? sel_bits : rd_data;
  assign io_count      = full ? 2'd2 : {1'b0, enq_ptr_q ^ deq_ptr_q};

  always_comb begin
    enq_ptr_d    = enq_ptr_q;
    deq_ptr_d    = deq_ptr_q;
    maybe_full_d = maybe_full_q;
    last_grant_d = last_grant_q;
    if (do_enq) enq_ptr_d = ~enq_ptr_q;
    if (do_deq) deq_ptr_d = ~deq_ptr_q;
    if (do_enq != do_deq) maybe_full_d = do_enq;
    // Any accepted handshake, bypass included, updates the round-robin history.
    if (sel_valid && !full) last_grant_d = sel;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      enq_ptr_q    <= 1'b0;
      deq_ptr_q    <= 1'b0;
      maybe_full_q <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      enq_ptr_q    <= enq_ptr_d;
      deq_ptr_q    <= deq_ptr_d;
      maybe_full_q <= maybe_full_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Storage is not cleared by reset; stale entries are unreachable until rewritten.
  always_ff @(posedge clock) begin
    if (do_enq) mem_q[enq_ptr_q] <= sel_bits;
  end

endmodule

// File: tb/tb_arb_queue_2x8.sv
// Bench for arb_queue_2x8: two instances (ARB_RR=1/FLOW=0 and ARB_RR=0/FLOW=1) share stimulus
// and are each compared every cycle against a queue-level reference model.
module tb_arb_queue_2x8;

  logic       clock = 1'b0;
  logic       reset;
  logic       enq0_valid, enq1_valid, deq_ready;
  logic [7:0] enq0_bits, enq1_bits;

  logic       enq0_ready [2];
  logic       enq1_ready [2];
  logic       deq_valid  [2];
  logic [7:0] deq_bits   [2];
  logic [1:0] count      [2];
  logic       chosen     [2];

  int checks = 0;
  int errors = 0;

  // Reference model state: occupancy plus FIFO contents (index 0 is the head).
  int         m_sz [2];
  logic [7:0] m_dat [2][2];
  logic       m_lg [2];
  bit         m_arb [2] = '{1'b1, 1'b0};
  bit         m_flw [2] = '{1'b0, 1'b1};

  always #5 clock = ~clock;

  arb_queue_2x8 #(.ARB_RR(1'b1), .FLOW(1'b0)) dut_rr (
    .clock(clock), .reset(reset),
    .io_enq0_valid(enq0_valid), .io_enq0_bits(enq0_bits), .io_enq0_ready(enq0_ready[0]),
    .io_enq1_valid(enq1_valid), .io_enq1_bits(enq1_bits), .io_enq1_ready(enq1_ready[0]),
    .io_deq_valid(deq_valid[0]), .io_deq_bits(deq_bits[0]), .io_deq_ready(deq_ready),
    .io_count(count[0]), .io_chosen(chosen[0])
  );

  arb_queue_2x8 #(.ARB_RR(1'b0), .FLOW(1'b1)) dut_flow (
    .clock(clock), .reset(reset),
    .io_enq0_valid(enq0_valid), .io_enq0_bits(enq0_bits), .io_enq0_ready(enq0_ready[1]),
    .io_enq1_valid(enq1_valid), .io_enq1_bits(enq1_bits), .io_enq1_ready(enq1_ready[1]),
    .io_deq_valid(deq_valid[1]), .io_deq_bits(deq_bits[1]), .io_deq_ready(deq_ready),
    .io_count(count[1]), .io_chosen(chosen[1])
  );

  task automatic chk(input string tag, input int inst, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] @%0t: observed %h expected %h", tag, inst, $time, obs, exp);
    end
  endtask

  function automatic logic pick(input int i);
    if (enq0_valid && enq1_valid) return m_arb[i] ? ~m_lg[i] : 1'b0;
    return enq1_valid;
  endfunction

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic       sel, sv, full, empty, exp_dv;
      logic [7:0] sbits;
      sel   = pick(i);
      sv    = enq0_valid | enq1_valid;
      sbits = sel ? enq1_bits : enq0_bits;
      full  = (m_sz[i] == 2);
      empty = (m_sz[i] == 0);
      exp_dv = !empty || (m_flw[i] && sv);
      chk("count", i, {6'd0, count[i]}, 8'(m_sz[i]));
      chk("chosen", i, {7'd0, chosen[i]}, {7'd0, sel});
      chk("enq0_ready", i, {7'd0, enq0_ready[i]}, {7'd0, !full && !sel});
      chk("enq1_ready", i, {7'd0, enq1_ready[i]}, {7'd0, !full && sel});
      chk("deq_valid", i, {7'd0, deq_valid[i]}, {7'd0, exp_dv});
      if (exp_dv) chk("deq_bits", i, deq_bits[i], empty ? sbits : m_dat[i][0]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sz[i] = 0;
      m_lg[i] = 1'b1;
    end
  endtask

  task automatic update_model();
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      logic       sel, sv, full, empty, de, dd;
      logic [7:0] sbits;
      sel   = pick(i);
      sv    = enq0_valid | enq1_valid;
      sbits = sel ? enq1_bits : enq0_bits;
      full  = (m_sz[i] == 2);
      empty = (m_sz[i] == 0);
      de = sv && !full && !(m_flw[i] && empty && deq_ready);
      dd = deq_ready && !empty;
      if (sv && !full) m_lg[i] = sel;
      if (dd) begin
        m_dat[i][0] = m_dat[i][1];
        m_sz[i]--;
      end
      if (de) begin
        m_dat[i][m_sz[i]] = sbits;
        m_sz[i]++;
      end
    end
  endtask

  task automatic cycle();
    #4;
    check_all();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] b0, input logic v1,
                       input logic [7:0] b1, input logic dr);
    enq0_valid = v0; enq0_bits = b0;
    enq1_valid = v1; enq1_bits = b1;
    deq_ready  = dr;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    cycle();  // still in reset: state already cleared
    reset = 1'b0;

    // T1: single enqueue, visible next cycle
    drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); cycle();
    cycle();

    // T2: fill to 2, hold full with both valid, then drain
    drive(1'b1, 8'hA1, 1'b0, 8'h00, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b1, 8'hA2, 1'b0); cycle();
    drive(1'b1, 8'hB0, 1'b1, 8'hB1, 1'b0); cycle();
    drive(1'b1, 8'hB0, 1'b1, 8'hB1, 1'b1); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); cycle();
    cycle();
    cycle();

    // T3: tie held, consumer always ready
    drive(1'b1, 8'h10, 1'b1, 8'h20, 1'b1);
    repeat (5) cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); repeat (3) cycle();

    // T4: prime one entry, then enq+deq every cycle across pointer wraps
    drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b0); cycle();
    for (int k = 2; k <= 6; k++) begin
      drive(1'b1, 8'(k), 1'b0, 8'h00, 1'b1); cycle();
    end
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); repeat (2) cycle();

    // T5: empty, enq1 only, consumer ready (bypass on the FLOW instance)
    drive(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); cycle();

    // T6: reset while full, then new data must not expose stale entries
    drive(1'b1, 8'hC1, 1'b0, 8'h00, 1'b0); cycle();
    drive(1'b1, 8'hC2, 1'b0, 8'h00, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0); reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    drive(1'b1, 8'h77, 1'b0, 8'h00, 1'b0); cycle();
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1); cycle();
    cycle();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 2) != 0));
      reset = ($urandom_range(0, 49) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
